// File: rtl/uvc_pkt_arb.sv
// Two-source round-robin packet arbiter feeding a shared TX FIFO.
// Grants are credit-metered per payload packet and guarded by an idle watchdog.
module uvc_pkt_arb #(
  parameter int PAYLOAD_SIZE = 1024,
  parameter int TIMEOUT      = 4096
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       FIFO_AFULL_I,
  input  logic       S0_VS_I,
  input  logic       S1_VS_I,
  input  logic [7:0] S0_DATA_I,
  input  logic [7:0] S1_DATA_I,
  input  logic       S0_DVAL_I,
  input  logic       S1_DVAL_I,
  output logic       S0_AFULL_O,
  output logic       S1_AFULL_O,
  output logic [7:0] DATA_O,
  output logic       DVAL_O,
  output logic [1:0] GNT_O,
  output logic       PKT_DONE_O,
  output logic       ERR_O
);

  localparam logic [15:0] PKT_LEN = 16'(PAYLOAD_SIZE);
  localparam logic [15:0] WD_LIM  = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_DRAIN,
    ST_GAP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        gnt_src;
  logic        gnt_src_nxt;
  logic        last;
  logic [15:0] credit;
  logic [15:0] acc;
  logic [15:0] wdog;
  logic        post_rst;
  logic [7:0]  data_q;
  logic        dval_q;
  logic        err_q;

  // View of the currently granted source and of the one left waiting.
  logic       g_vs;
  logic       g_dval;
  logic       o_dval;
  logic [7:0] g_data;

  logic active;
  logic credit_ok;
  logic accept;
  logic silent;
  logic wdog_fire;
  logic pkt_full;
  logic stray;
  logic overrun;
  logic start_grant;

  assign g_vs   = gnt_src ? S1_VS_I   : S0_VS_I;
  assign g_dval = gnt_src ? S1_DVAL_I : S0_DVAL_I;
  assign o_dval = gnt_src ? S0_DVAL_I : S1_DVAL_I;
  assign g_data = gnt_src ? S1_DATA_I : S0_DATA_I;

  assign active    = (state == ST_GRANT) || (state == ST_DRAIN);
  assign credit_ok = (state == ST_GRANT) && !FIFO_AFULL_I && (credit < PKT_LEN);
  assign accept    = active && g_dval;
  assign silent    = (state == ST_GRANT) && !g_dval && !FIFO_AFULL_I;
  assign wdog_fire = silent && (wdog == WD_LIM - 16'd1);
  assign pkt_full  = credit_ok && (credit == PKT_LEN - 16'd1);

  // Outside a grant any byte is stray, except the one a source may still
  // push in the cycle right after reset.
  assign stray   = active ? o_dval : ((S0_DVAL_I || S1_DVAL_I) && !post_rst);
  assign overrun = accept && (acc >= credit);

  assign start_grant = (state == ST_IDLE) && (state_nxt == ST_GRANT);

  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    gnt_src_nxt = gnt_src;
    case (state)
      ST_IDLE: begin
        if (S0_VS_I || S1_VS_I) begin
          state_nxt   = ST_GRANT;
          gnt_src_nxt = (S0_VS_I && S1_VS_I) ? ~last : S1_VS_I;
        end
      end
      ST_GRANT: begin
        if (!g_vs || pkt_full || wdog_fire) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: state_nxt = ST_GAP;
      ST_GAP:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state    <= ST_IDLE;
      gnt_src  <= 1'b0;
      last     <= 1'b1;
      credit   <= 16'd0;
      acc      <= 16'd0;
      wdog     <= 16'd0;
      post_rst <= 1'b1;
      data_q   <= 8'h00;
      dval_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt_src  <= gnt_src_nxt;
      post_rst <= 1'b0;

      if (start_grant) begin
        credit <= 16'd0;
        acc    <= 16'd0;
        wdog   <= 16'd0;
      end else begin
        if (credit_ok) begin
          credit <= credit + 16'd1;
        end
        if (accept && (acc != 16'hFFFF)) begin
          acc <= acc + 16'd1;
        end
        if (state == ST_GRANT) begin
          wdog <= silent ? wdog + 16'd1 : 16'd0;
        end
      end

      if (state == ST_GAP) begin
        last <= gnt_src;
      end

      dval_q <= accept;
      if (accept) begin
        data_q <= g_data;
      end

      if (stray || overrun || wdog_fire) begin
        err_q <= 1'b1;
      end
    end
  end

  assign S0_AFULL_O = !(credit_ok && !gnt_src);
  assign S1_AFULL_O = !(credit_ok &&  gnt_src);
  assign DATA_O     = data_q;
  assign DVAL_O     = dval_q;
  assign GNT_O      = active ? (gnt_src ? 2'b10 : 2'b01) : 2'b00;
  assign PKT_DONE_O = (state == ST_GAP);
  assign ERR_O      = err_q;

endmodule

// File: tb/tb_uvc_pkt_arb.sv
// Directed bench for uvc_pkt_arb: credit-obeying source models, an output
// monitor and hand-computed expectations for each scenario.
`timescale 1ns/1ps
module tb_uvc_pkt_arb;

  localparam int P  = 16;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_afull;
  logic       s0_vs, s1_vs, s0_dval, s1_dval;
  logic [7:0] s0_data, s1_data;
  logic       s0_afull, s1_afull, dval_o, pkt_done, err;
  logic [7:0] data_o;
  logic [1:0] gnt;

  always #5 clk = ~clk;

  uvc_pkt_arb #(.PAYLOAD_SIZE(P), .TIMEOUT(TO)) dut (
    .CLK_I        (clk),
    .RST_I        (rst),
    .FIFO_AFULL_I (fifo_afull),
    .S0_VS_I      (s0_vs),
    .S1_VS_I      (s1_vs),
    .S0_DATA_I    (s0_data),
    .S1_DATA_I    (s1_data),
    .S0_DVAL_I    (s0_dval),
    .S1_DVAL_I    (s1_dval),
    .S0_AFULL_O   (s0_afull),
    .S1_AFULL_O   (s1_afull),
    .DATA_O       (data_o),
    .DVAL_O       (dval_o),
    .GNT_O        (gnt),
    .PKT_DONE_O   (pkt_done),
    .ERR_O        (err)
  );

  int tests = 0;
  int fails = 0;

  // Pending inputs, applied at the next falling edge.
  bit n_rst, n_fifo;
  bit n_vs [2];
  bit stray_req;

  int left [2];
  int sent [2];
  int out_cnt [2];
  int low_cnt [2];
  int gcnt [2];
  bit afull_q [2];
  int done_cnt, data_err, bad_afull, own;
  logic [1:0] prev_gnt;
  logic [1:0] hist [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] hist_at(input int i);
    if (i < hist.size()) return hist[i];
    return 2'b11;
  endfunction

  task automatic cycle();
    logic       v [2];
    logic [7:0] d [2];
    @(negedge clk);
    rst        = n_rst;
    fifo_afull = n_fifo;
    s0_vs      = n_vs[0];
    s1_vs      = n_vs[1];
    for (int s = 0; s < 2; s++) begin
      v[s] = !afull_q[s] && (left[s] > 0);
      d[s] = v[s] ? 8'(s * 128 + sent[s] % 128) : 8'h00;
      if (v[s]) begin
        sent[s]++;
        left[s]--;
      end
    end
    if (stray_req) begin
      v[1] = 1'b1;
      d[1] = 8'hEE;
      stray_req = 1'b0;
    end
    s0_dval = v[0]; s0_data = d[0];
    s1_dval = v[1]; s1_data = d[1];
    #1;
    afull_q[0] = (s0_afull !== 1'b0);
    afull_q[1] = (s1_afull !== 1'b0);
    if (s0_afull === 1'b0) low_cnt[0]++;
    if (s1_afull === 1'b0) low_cnt[1]++;
    if (!rst) begin
      if (gnt == 2'b01 && s1_afull !== 1'b1) bad_afull++;
      if (gnt == 2'b10 && s0_afull !== 1'b1) bad_afull++;
      if (gnt == 2'b00 && (s0_afull !== 1'b1 || s1_afull !== 1'b1)) bad_afull++;
    end
    if (gnt == 2'b01) own = 0;
    else if (gnt == 2'b10) own = 1;
    if (gnt == 2'b01 || gnt == 2'b10) gcnt[own]++;
    if ((gnt == 2'b01 || gnt == 2'b10) && prev_gnt == 2'b00) hist.push_back(gnt);
    prev_gnt = gnt;
    if (pkt_done === 1'b1) done_cnt++;
    if (dval_o === 1'b1) begin
      if (data_o !== 8'(own * 128 + out_cnt[own] % 128)) data_err++;
      out_cnt[own]++;
    end
  endtask

  task automatic clear_counts();
    for (int s = 0; s < 2; s++) begin
      sent[s] = 0; out_cnt[s] = 0; low_cnt[s] = 0; gcnt[s] = 0;
    end
    done_cnt = 0; data_err = 0; bad_afull = 0; own = 0;
    prev_gnt = 2'b00;
    hist.delete();
  endtask

  task automatic do_reset();
    n_rst = 1'b1; n_fifo = 1'b0; n_vs[0] = 1'b0; n_vs[1] = 1'b0;
    left[0] = 0; left[1] = 0; stray_req = 1'b0;
    cycle();
    cycle();
    clear_counts();
    n_rst = 1'b0;
  endtask

  task automatic run_until_done(input int n, input string tag);
    for (int i = 0; i < 300 && done_cnt < n; i++) cycle();
    check(tag, 32'(done_cnt), 32'(n));
  endtask

  initial begin
    afull_q[0] = 1'b1; afull_q[1] = 1'b1;
    rst = 1'b1; fifo_afull = 1'b0; s0_vs = 1'b0; s1_vs = 1'b0;
    s0_dval = 1'b0; s1_dval = 1'b0; s0_data = 8'h00; s1_data = 8'h00;

    // Reset values
    do_reset();
    check("rst_outputs", 32'({s0_afull, s1_afull, data_o, dval_o, gnt, pkt_done, err}),
          32'({1'b1, 1'b1, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0}));

    // Single source, one full packet then re-grant to the same source
    n_vs[0] = 1'b1; left[0] = 1000;
    run_until_done(1, "s0_done");
    check("s0_afull_low", 32'(low_cnt[0]), 32'd16);
    check("s0_bytes", 32'(out_cnt[0]), 32'd16);
    check("s0_order", 32'(data_err), 32'd0);
    for (int i = 0; i < 20 && hist.size() < 2; i++) cycle();
    check("s0_first_gnt", 32'(hist_at(0)), 32'd1);
    check("s0_regrant", 32'(hist_at(1)), 32'd1);

    // Both sources: alternating grants, S0 first after reset
    do_reset();
    n_vs[0] = 1'b1; n_vs[1] = 1'b1; left[0] = 1000; left[1] = 1000;
    run_until_done(3, "rr_done");
    check("rr_gnt0", 32'(hist_at(0)), 32'd1);
    check("rr_gnt1", 32'(hist_at(1)), 32'd2);
    check("rr_gnt2", 32'(hist_at(2)), 32'd1);
    check("rr_bytes_s0", 32'(out_cnt[0]), 32'd32);
    check("rr_bytes_s1", 32'(out_cnt[1]), 32'd16);
    check("rr_afull_nongnt", 32'(bad_afull), 32'd0);
    check("rr_order", 32'(data_err), 32'd0);

    // FIFO almost-full toggling 1 high / 3 low
    do_reset();
    n_vs[0] = 1'b1; left[0] = 1000;
    for (int i = 0; i < 300 && done_cnt < 2; i++) begin
      n_fifo = (i % 4 == 0);
      cycle();
    end
    n_fifo = 1'b0;
    check("stall_done", 32'(done_cnt), 32'd2);
    check("stall_bytes", 32'(out_cnt[0]), 32'd32);
    check("stall_order", 32'(data_err), 32'd0);
    check("stall_err", 32'(err), 32'd0);

    // Short packet: S0 frame ends after 7 credits, S1 waits
    do_reset();
    n_vs[0] = 1'b1; n_vs[1] = 1'b1; left[0] = 7; left[1] = 1000;
    for (int i = 0; i < 300 && hist.size() < 2; i++) begin
      if (low_cnt[0] >= 7) n_vs[0] = 1'b0;
      cycle();
    end
    check("short_done", 32'(done_cnt), 32'd1);
    check("short_bytes", 32'(out_cnt[0]), 32'd7);
    check("short_gnt_cycles", 32'(gcnt[0]), 32'd9);
    check("short_next_s1", 32'(hist_at(1)), 32'd2);
    check("short_err", 32'(err), 32'd0);

    // Reset in the middle of a packet
    do_reset();
    n_vs[0] = 1'b1; left[0] = 1000;
    for (int i = 0; i < 50 && low_cnt[0] < 5; i++) cycle();
    check("abort_reached", 32'(low_cnt[0]), 32'd5);
    n_rst = 1'b1; n_vs[0] = 1'b0;
    cycle();
    n_rst = 1'b0;
    done_cnt = 0;
    begin
      int base;
      base = out_cnt[0];
      for (int i = 0; i < 4; i++) cycle();
      check("abort_drop", 32'(out_cnt[0] - base), 32'd0);
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_no_err", 32'(err), 32'd0);

    // Watchdog: granted source never sends
    do_reset();
    n_vs[0] = 1'b1; left[0] = 0;
    run_until_done(1, "wd_revoke");
    check("wd_cycles", 32'(low_cnt[0]), 32'd8);
    check("wd_err", 32'(err), 32'd1);
    n_vs[0] = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    check("wd_err_sticky", 32'(err), 32'd1);
    do_reset();
    check("wd_err_clear", 32'(err), 32'd0);

    // Stray byte from the non-granted source
    n_vs[0] = 1'b1; left[0] = 1000;
    begin
      bit injected;
      injected = 1'b0;
      for (int i = 0; i < 300 && done_cnt < 1; i++) begin
        if (low_cnt[0] == 5 && !injected) begin
          stray_req = 1'b1;
          injected  = 1'b1;
        end
        cycle();
      end
    end
    check("stray_done", 32'(done_cnt), 32'd1);
    check("stray_bytes", 32'(out_cnt[0]), 32'd16);
    check("stray_blocked", 32'(data_err), 32'd0);
    check("stray_err", 32'(err), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
